// File: rtl/arb_pkg.sv
// Shared types and default parameters for the two-requester bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_A1 = 2'd1,
        GNT_A2 = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_A1 = 1'b0,
        OWN_A2 = 1'b1
    } owner_e;

    localparam int unsigned SYNC_STAGES_D = 2;
    localparam int unsigned MAX_TENURE_D  = 16;
    localparam int unsigned IDLE_GAP_D    = 1;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/req_sync.sv
// Single-bit multi-flop synchroniser bringing an asynchronous request into the arbiter clock.
module req_sync
    import arb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_D
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; stage 0 is the metastability-exposed capture flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for two DevA requesters with bounded tenure and a turnaround gap.
module bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_D,
    parameter int unsigned MAX_TENURE  = MAX_TENURE_D,
    parameter int unsigned IDLE_GAP    = IDLE_GAP_D
) (
    input  logic clkArb,
    input  logic rst,
    input  logic reqA1,
    input  logic reqA2,
    output logic gntA1,
    output logic gntA2,
    output logic busBusy
);

    localparam int unsigned TEN_W = cnt_width(MAX_TENURE);
    localparam int unsigned GAP_W = cnt_width(IDLE_GAP);
    localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

    logic s1;
    logic s2;

    arb_state_e        state_q, state_d;
    logic [TEN_W-1:0]  tenure_q, tenure_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    owner_e            last_owner_q, last_owner_d;
    logic              gnt_a1_q, gnt_a2_q, busy_q;

    req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a1 (
        .clk     (clkArb),
        .rst_n   (rst),
        .async_i (reqA1),
        .sync_o  (s1)
    );

    req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a2 (
        .clk     (clkArb),
        .rst_n   (rst),
        .async_i (reqA2),
        .sync_o  (s2)
    );

    // State, counters and grant registers; grants follow the next state so they align with it.
    always_ff @(posedge clkArb) begin
        if (!rst) begin
            state_q      <= IDLE;
            tenure_q     <= '0;
            gap_q        <= '0;
            last_owner_q <= OWN_A2;
            gnt_a1_q     <= 1'b0;
            gnt_a2_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tenure_q     <= tenure_d;
            gap_q        <= gap_d;
            last_owner_q <= last_owner_d;
            gnt_a1_q     <= (state_d == GNT_A1);
            gnt_a2_q     <= (state_d == GNT_A2);
            busy_q       <= (state_d == GNT_A1) || (state_d == GNT_A2);
        end
    end

    // Next-state: arbitrate in IDLE, bound tenure while the other side waits, hold GAP for turnaround.
    always_comb begin
        state_d      = state_q;
        tenure_d     = tenure_q;
        gap_d        = gap_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                if (s1 && (!s2 || (last_owner_q == OWN_A2))) begin
                    state_d      = GNT_A1;
                    tenure_d     = '0;
                    last_owner_d = OWN_A1;
                end else if (s2) begin
                    state_d      = GNT_A2;
                    tenure_d     = '0;
                    last_owner_d = OWN_A2;
                end
            end
            GNT_A1: begin
                if (!s1) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else if (tenure_q == TEN_LAST) begin
                    if (s2) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        tenure_d = '0;
                    end
                end else begin
                    tenure_d = tenure_q + TEN_W'(1);
                end
            end
            GNT_A2: begin
                if (!s2) begin
                    state_d = GAP;
                    gap_d   = '0;
                end else if (tenure_q == TEN_LAST) begin
                    if (s1) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        tenure_d = '0;
                    end
                end else begin
                    tenure_d = tenure_q + TEN_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gntA1   = gnt_a1_q;
    assign gntA2   = gnt_a2_q;
    assign busBusy = busy_q;

endmodule
